// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: fetch/decode/execute/memory/writeback sequencing.
// Optional performance counters (retired_cnt, stall_cnt) are enabled by defining RV_CTRL_PERF_EN.
module rv_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter logic [1:0]  RESET_PC_SEL = 2'd0
) (
    input  logic        clock,
    input  logic        n_reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  fncode,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        illegal,
    output logic [2:0]  state_o
`ifdef RV_CTRL_PERF_EN
    ,
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Wide enough to hold MEM_TIMEOUT and still saturate above it.
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 2);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               waiting;
    logic               wait_hit;
    logic               legal;
    logic               is_store;

    function automatic logic decode_legal(input logic [6:0] op, input logic [2:0] f3);
        logic ok;
        case (op)
            OP_LUI, OP_AUIPC, OP_IMM, OP_OP,
            OP_JAL, OP_JALR, OP_BRANCH: ok = 1'b1;
            OP_LOAD:                    ok = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
            OP_STORE:                   ok = (f3 <= 3'b010);
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign legal    = decode_legal(opcode, fncode);
    assign is_store = (opcode == OP_STORE);
    assign waiting  = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready;
    assign wait_hit = (MEM_TIMEOUT != 0) && (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)     state_d = S_DECODE;
                else if (wait_hit) state_d = S_TRAP;
            end
            S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    OP_BRANCH:         state_d = S_FETCH;
                    default:           state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready)     state_d = is_store ? S_FETCH : S_WB;
                else if (wait_hit) state_d = S_TRAP;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q)
            wait_cnt_d = '0;
        else if (waiting && wait_cnt_q != '1)
            wait_cnt_d = wait_cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'd0;
        rf_we        = 1'b0;
        wb_sel       = 2'd0;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        illegal      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
            end
            S_DECODE: illegal = !legal;
            S_EXEC: begin
                case (opcode)
                    OP_IMM, OP_LOAD, OP_STORE: alu_b_sel = 1'b1;
                    OP_AUIPC: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                    end
                    OP_JAL: begin
                        pc_we  = 1'b1;
                        pc_src = 2'd1;
                    end
                    OP_JALR: begin
                        pc_we  = 1'b1;
                        pc_src = 2'd2;
                    end
                    OP_BRANCH: begin
                        pc_we  = branch_taken;
                        pc_src = 2'd1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store;
            end
            S_WB: begin
                rf_we = 1'b1;
                case (opcode)
                    OP_LOAD:         wb_sel = 2'd1;
                    OP_JAL, OP_JALR: wb_sel = 2'd2;
                    OP_LUI:          wb_sel = 2'd3;
                    default:         wb_sel = 2'd0;
                endcase
            end
            S_TRAP: begin
                pc_we  = 1'b1;
                pc_src = 2'd3;
            end
            default: ;
        endcase
        // NOTE: reset gates the outputs combinationally so an in-flight request drops without a clock.
        if (!n_reset) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_we        = 1'b0;
            pc_we        = 1'b0;
            pc_src       = RESET_PC_SEL;
            rf_we        = 1'b0;
            wb_sel       = 2'd0;
            alu_a_sel    = 1'b0;
            alu_b_sel    = 1'b0;
            illegal      = 1'b0;
        end
    end

    assign state_o = state_q;

`ifdef RV_CTRL_PERF_EN
    logic [31:0] retired_q, retired_d;
    logic [31:0] stall_q, stall_d;
    logic        retire;

    assign retire = (state_q == S_WB)
                 || (state_q == S_MEM  && mem_ready && is_store)
                 || (state_q == S_EXEC && opcode == OP_BRANCH);

    always_comb begin
        retired_d = retired_q;
        stall_d   = stall_q;
        if (retire)
            retired_d = retired_q + 32'd1;
        // The cycle that times out to TRAP is not counted as a stall.
        if (waiting && state_d != S_TRAP)
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: stimulus pushes hand-computed per-cycle output vectors,
// a negedge monitor pops and compares them against the DUT (and a MEM_TIMEOUT=0 twin).
module tb_rv_multicycle_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       asel;
        logic       irwe;
        logic       pcwe;
        logic [1:0] pcs;
        logic       rfwe;
        logic [1:0] wbs;
        logic       a;
        logic       b;
        logic       ill;
    } obs_t;

    typedef struct {
        string nm;
        obs_t  v;
        bit    chk_alt;
        obs_t  alt;
    } exp_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic       clock = 1'b0;
    logic       n_reset;
    logic [6:0] opcode;
    logic [2:0] fncode;
    logic       branch_taken;
    logic       mem_ready;

    logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, alu_a_sel, alu_b_sel, illegal;
    logic [1:0] pc_src, wb_sel;
    logic [2:0] state_o;

    logic       mem_req_z, mem_we_z, mem_addr_sel_z, ir_we_z, pc_we_z, rf_we_z, alu_a_sel_z, alu_b_sel_z, illegal_z;
    logic [1:0] pc_src_z, wb_sel_z;
    logic [2:0] state_o_z;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    rv_multicycle_ctrl #(.MEM_TIMEOUT(16), .RESET_PC_SEL(2'd0)) dut (
        .clock(clock), .n_reset(n_reset), .opcode(opcode), .fncode(fncode),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .wb_sel(wb_sel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .illegal(illegal), .state_o(state_o)
    );

    rv_multicycle_ctrl #(.MEM_TIMEOUT(0), .RESET_PC_SEL(2'd0)) dut_z (
        .clock(clock), .n_reset(n_reset), .opcode(opcode), .fncode(fncode),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req_z), .mem_we(mem_we_z), .mem_addr_sel(mem_addr_sel_z), .ir_we(ir_we_z),
        .pc_we(pc_we_z), .pc_src(pc_src_z), .rf_we(rf_we_z), .wb_sel(wb_sel_z),
        .alu_a_sel(alu_a_sel_z), .alu_b_sel(alu_b_sel_z), .illegal(illegal_z), .state_o(state_o_z)
    );

    obs_t act, act_z;
    assign act   = {state_o, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
                    rf_we, wb_sel, alu_a_sel, alu_b_sel, illegal};
    assign act_z = {state_o_z, mem_req_z, mem_we_z, mem_addr_sel_z, ir_we_z, pc_we_z, pc_src_z,
                    rf_we_z, wb_sel_z, alu_a_sel_z, alu_b_sel_z, illegal_z};

    function automatic obs_t o(input logic [2:0] st, input logic req, input logic we,
                               input logic asel, input logic irwe, input logic pcwe,
                               input logic [1:0] pcs, input logic rfwe, input logic [1:0] wbs,
                               input logic a, input logic b, input logic ill);
        return {st, req, we, asel, irwe, pcwe, pcs, rfwe, wbs, a, b, ill};
    endfunction

    // Field order in printed vectors: st req we asel irwe pcwe pcs rfwe wbs a b ill
    task automatic check(input string nm, input obs_t got, input obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got st=%0d %b_%b_%b_%b_%b pcs=%0d rf=%b wbs=%0d a=%b b=%b ill=%b, expected st=%0d %b_%b_%b_%b_%b pcs=%0d rf=%b wbs=%0d a=%b b=%b ill=%b",
                     nm, got.st, got.req, got.we, got.asel, got.irwe, got.pcwe, got.pcs, got.rfwe,
                     got.wbs, got.a, got.b, got.ill,
                     want.st, want.req, want.we, want.asel, want.irwe, want.pcwe, want.pcs, want.rfwe,
                     want.wbs, want.a, want.b, want.ill);
        end
    endtask

    always @(negedge clock) begin
        exp_t x;
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            check(x.nm, act, x.v);
            if (x.chk_alt) check({x.nm, "/to0"}, act_z, x.alt);
        end
    end

    task automatic step(input logic rst_v, input logic [6:0] op, input logic [2:0] f3,
                        input logic bt, input logic rdy, input string nm, input obs_t e,
                        input bit chk_alt = 1'b0, input obs_t alt = '0);
        exp_t x;
        @(posedge clock);
        #1;
        n_reset      = rst_v;
        opcode       = op;
        fncode       = f3;
        branch_taken = bt;
        mem_ready    = rdy;
        x.nm = nm; x.v = e; x.chk_alt = chk_alt; x.alt = alt;
        exp_q.push_back(x);
    endtask

    obs_t RST, F_OK, F_WAIT, DEC, DEC_ILL, TRAP_O;

    task automatic run4(input string nm, input logic [6:0] op, input logic [2:0] f3,
                        input logic rdy_idle, input obs_t e_exec, input obs_t e_wb);
        step(1, op, f3, 0, 1,        {nm, "/F"}, F_OK);
        step(1, op, f3, 0, rdy_idle, {nm, "/D"}, DEC);
        step(1, op, f3, 0, rdy_idle, {nm, "/E"}, e_exec);
        step(1, op, f3, 0, rdy_idle, {nm, "/W"}, e_wb);
    endtask

    task automatic run_illegal(input string nm, input logic [6:0] op, input logic [2:0] f3);
        step(1, op, f3, 0, 1, {nm, "/F"}, F_OK);
        step(1, op, f3, 0, 0, {nm, "/D"}, DEC_ILL);
        step(1, op, f3, 0, 0, {nm, "/T"}, TRAP_O);
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        RST     = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        F_OK    = o(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        F_WAIT  = o(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        DEC     = o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        DEC_ILL = o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        TRAP_O  = o(5, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);

        n_reset = 1'b0; opcode = '0; fncode = '0; branch_taken = 1'b0; mem_ready = 1'b0;

        step(0, 0, 0, 0, 1, "reset0", RST, 1'b1, RST);
        step(0, 0, 0, 0, 1, "reset1", RST);

        // mem_ready stays high through DECODE/EXEC/WB for addi and must be ignored there.
        run4("addi",  OP_IMM,   3'b000, 1, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), o(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        run4("add",   OP_OP,    3'b000, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), o(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        run4("lui",   OP_LUI,   3'b000, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), o(4, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0));
        run4("auipc", OP_AUIPC, 3'b000, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), o(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        run4("jal",   OP_JAL,   3'b000, 0, o(2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), o(4, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
        run4("jalr",  OP_JALR,  3'b000, 0, o(2, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0), o(4, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));

        // lw with three wait states in MEM: 8 cycles, mem_req high for all 4 MEM cycles.
        step(1, OP_LOAD, 3'b010, 0, 1, "lw/F",  F_OK);
        step(1, OP_LOAD, 3'b010, 0, 0, "lw/D",  DEC);
        step(1, OP_LOAD, 3'b010, 0, 0, "lw/E",  o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++)
            step(1, OP_LOAD, 3'b010, 0, 0, "lw/Mwait", o(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(1, OP_LOAD, 3'b010, 0, 1, "lw/Mrdy", o(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(1, OP_LOAD, 3'b010, 0, 0, "lw/W",  o(4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));

        // lbu (fncode 100) is a legal load.
        step(1, OP_LOAD, 3'b100, 0, 1, "lbu/F", F_OK);
        step(1, OP_LOAD, 3'b100, 0, 0, "lbu/D", DEC);
        step(1, OP_LOAD, 3'b100, 0, 0, "lbu/E", o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step(1, OP_LOAD, 3'b100, 0, 1, "lbu/M", o(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(1, OP_LOAD, 3'b100, 0, 0, "lbu/W", o(4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));

        // sw (fncode 010, the highest legal store width) returns to FETCH straight from MEM.
        step(1, OP_STORE, 3'b010, 0, 1, "sw/F", F_OK);
        step(1, OP_STORE, 3'b010, 0, 0, "sw/D", DEC);
        step(1, OP_STORE, 3'b010, 0, 0, "sw/E", o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step(1, OP_STORE, 3'b010, 0, 1, "sw/M", o(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

        step(1, OP_BRANCH, 3'b000, 1, 1, "beq_t/F", F_OK);
        step(1, OP_BRANCH, 3'b000, 1, 0, "beq_t/D", DEC);
        step(1, OP_BRANCH, 3'b000, 1, 0, "beq_t/E", o(2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        step(1, OP_BRANCH, 3'b000, 0, 1, "beq_n/F", F_OK);
        step(1, OP_BRANCH, 3'b000, 0, 0, "beq_n/D", DEC);
        step(1, OP_BRANCH, 3'b000, 0, 0, "beq_n/E", o(2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

        run_illegal("bad_op", OP_BAD,   3'b000);
        run_illegal("bad_ld", OP_LOAD,  3'b011);
        run_illegal("bad_st", OP_STORE, 3'b011);

        // Fetch stalls: timeout-16 traps after 16 wait cycles (twice); the timeout-0 twin keeps waiting.
        for (int i = 0; i < 34; i++)
            step(1, OP_IMM, 3'b000, 0, 0, (i == 16 || i == 33) ? "tmo/T" : "tmo/Fwait",
                 (i == 16 || i == 33) ? TRAP_O : F_WAIT, 1'b1, F_WAIT);
        step(1, OP_STORE, 3'b010, 0, 1, "tmo/Frdy", F_OK, 1'b1, F_OK);

        // Reset asserted while the store is waiting in MEM.
        step(1, OP_STORE, 3'b010, 0, 0, "rst_st/D", DEC);
        step(1, OP_STORE, 3'b010, 0, 0, "rst_st/E", o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step(1, OP_STORE, 3'b010, 0, 0, "rst_st/M", o(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(1, OP_STORE, 3'b010, 0, 0, "rst_st/M2", o(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, OP_STORE, 3'b010, 0, 1, "rst_st/async", RST, 1'b1, RST);
        step(0, OP_STORE, 3'b010, 0, 1, "rst_st/hold", RST);
        step(1, OP_IMM, 3'b000, 0, 0, "rst_st/Fwait", F_WAIT);
        run4("post_rst", OP_IMM, 3'b000, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), o(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
